image_window_streamer: RTL and testbench

Transmit side of the classifier pixel interface. Accepts whole 3x3 signed-pixel images from a loader and streams the four overlapping 2x2 windows, one window per accepted transfer, in the fixed order the 2x2 convolution datapath in Top consumes on its pixels input. A DEPTH-entry image FIFO lets the next image be loaded while the current one streams. Output handshake is valid/ready, so the classifier can stall the stream.

---
 rtl/image_window_streamer_if.sv | 39 +++
 rtl/image_window_streamer.sv | 121 ++++++++++++
 tb/tb_image_window_streamer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_window_streamer_if.sv
// Stream bundle for the image window streamer: the image load side and the
// 2x2 window output side. The streamer itself uses the master modport.
interface image_window_streamer_if #(
    parameter int PIX_W = 8
);
    logic                 img_valid;
    logic [9*PIX_W-1:0]   img_data;
    logic                 img_ready;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [4*PIX_W-1:0]   pixels;
    logic [1:0]           win_idx;
    logic                 win_first;
    logic                 win_last;

    modport master (
        input  img_valid,
        input  img_data,
        input  pix_ready,
        output img_ready,
        output pix_valid,
        output pixels,
        output win_idx,
        output win_first,
        output win_last
    );

    modport slave (
        output img_valid,
        output img_data,
        output pix_ready,
        input  img_ready,
        input  pix_valid,
        input  pixels,
        input  win_idx,
        input  win_first,
        input  win_last
    );
endinterface

// File: rtl/image_window_streamer.sv
// Buffers whole 3x3 images in a small FIFO and streams the four overlapping
// 2x2 windows of the head image, one per valid/ready transfer.
module image_window_streamer #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    output logic [CNT_W-1:0]     frame_cnt,
    image_window_streamer_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int IMG_W = 9 * PIX_W;
    localparam int WIN_W = 4 * PIX_W;

    logic [IMG_W-1:0] img_q [DEPTH];
    logic [IMG_W-1:0] img_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [1:0]       win_idx_q, win_idx_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             xfer;
    logic             pop;
    logic [IMG_W-1:0] head;
    logic [WIN_W-1:0] window;

    function automatic logic [PIX_W-1:0] pick(input logic [IMG_W-1:0] img,
                                             input int r, input int c);
        return img[(r*3+c)*PIX_W +: PIX_W];
    endfunction

    // Readiness depends on registered occupancy only, so a same-cycle pop
    // never opens the input side.
    always_comb begin
        not_full  = occ_q < OCC_W'(DEPTH);
        not_empty = occ_q != '0;
        push      = bus.img_valid && not_full && !flush;
        xfer      = not_empty && bus.pix_ready;
        pop       = xfer && (win_idx_q == 2'd3) && !flush;
    end

    always_comb begin
        img_d       = img_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        win_idx_d   = win_idx_q;
        frame_cnt_d = frame_cnt_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
            win_idx_d = 2'd0;
        end else begin
            if (push) begin
                img_d[wr_ptr_q] = bus.img_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (xfer) begin
                win_idx_d = win_idx_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            win_idx_q   <= 2'd0;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            win_idx_q   <= win_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Image storage is pure datapath; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        img_q <= img_d;
    end

    // Window k covers rows (2-k/2, 1-k/2) and columns (2-k%2, 1-k%2).
    always_comb begin
        head = img_q[rd_ptr_q];
        case (win_idx_q)
            2'd0:    window = {pick(head, 2, 2), pick(head, 2, 1), pick(head, 1, 2), pick(head, 1, 1)};
            2'd1:    window = {pick(head, 2, 1), pick(head, 2, 0), pick(head, 1, 1), pick(head, 1, 0)};
            2'd2:    window = {pick(head, 1, 2), pick(head, 1, 1), pick(head, 0, 2), pick(head, 0, 1)};
            default: window = {pick(head, 1, 1), pick(head, 1, 0), pick(head, 0, 1), pick(head, 0, 0)};
        endcase
    end

    assign bus.img_ready = not_full;
    assign bus.pix_valid = not_empty;
    assign bus.pixels    = not_empty ? window : '0;
    assign bus.win_idx   = win_idx_q;
    assign bus.win_first = not_empty && (win_idx_q == 2'd0);
    assign bus.win_last  = not_empty && (win_idx_q == 2'd3);
    assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_image_window_streamer.sv
// Scoreboard bench for image_window_streamer: expected windows are queued as
// images are driven and checked by a monitor on every output transfer.
module tb_image_window_streamer;
    typedef struct packed {
        logic [31:0] pix;
        logic [1:0]  idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] frame_cnt;
    logic [1:0] frame_cnt2;

    image_window_streamer_if #(.PIX_W(8)) bus ();
    image_window_streamer_if #(.PIX_W(8)) bus2 ();

    image_window_streamer #(.PIX_W(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .frame_cnt (frame_cnt),
        .bus       (bus)
    );

    image_window_streamer #(.PIX_W(8), .DEPTH(2), .CNT_W(2)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .frame_cnt (frame_cnt2),
        .bus       (bus2)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   n_xfer = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Every output transfer must match the oldest outstanding expected window.
    always @(negedge clk) begin
        if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
            n_xfer++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL xfer_unexpected: got pixels=%h idx=%0d, required no transfer",
                         bus.pixels, bus.win_idx);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.pixels, bus.win_idx, bus.win_first, bus.win_last} !==
                    {mon_e.pix, mon_e.idx, mon_e.idx == 2'd0, mon_e.idx == 2'd3}) begin
                    bad++;
                    $display("[TB] FAIL window: got pixels=%h idx=%0d first=%b last=%b, required pixels=%h idx=%0d",
                             bus.pixels, bus.win_idx, bus.win_first, bus.win_last, mon_e.pix, mon_e.idx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_win(input logic [71:0] img, input int k);
        logic [7:0] p [3][3];
        int ro;
        int co;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = img[(r*3+c)*8 +: 8];
        ro = k / 2;
        co = k % 2;
        return {p[2-ro][2-co], p[2-ro][1-co], p[1-ro][2-co], p[1-ro][1-co]};
    endfunction

    function automatic logic [71:0] rand_img();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_img(input logic [71:0] img);
        for (int k = 0; k < 4; k++) sb.push_back('{pix: model_win(img, k), idx: 2'(k)});
    endtask

    task automatic expect_lit(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        sb.push_back('{pix: w0, idx: 2'd0});
        sb.push_back('{pix: w1, idx: 2'd1});
        sb.push_back('{pix: w2, idx: 2'd2});
        sb.push_back('{pix: w3, idx: 2'd3});
    endtask

    task automatic push_raw(input logic [71:0] img);
        bit done = 0;
        bus.img_valid = 1'b1;
        bus.img_data  = img;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.img_ready === 1'b1) done = 1;
            step();
        end
        bus.img_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL push_timeout: got img_ready=%b for 200 cycles, required 1", bus.img_ready);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (sb.size() == 0 && bus.pix_valid !== 1'b1) done = 1;
            else step();
        end
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d windows pending, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        flush          = 1'b0;
        bus.img_valid  = 1'b0;
        bus.img_data   = '0;
        bus.pix_ready  = 1'b0;
        bus2.img_valid = 1'b0;
        bus2.img_data  = '0;
        bus2.pix_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({bus.pix_valid, bus.pixels, bus.win_first, bus.win_last, bus.img_ready, bus.win_idx} !==
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("[TB] FAIL %s_outputs: got valid=%b pixels=%h first=%b last=%b ready=%b idx=%0d, required 0 0 0 0 1 0",
                     tag, bus.pix_valid, bus.pixels, bus.win_first, bus.win_last, bus.img_ready, bus.win_idx);
        end
        total++;
        if (frame_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL %s_frame_cnt: got %0d, required 0", tag, frame_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
        total++;
        if ({bus2.pix_valid, bus2.img_ready, frame_cnt2} !== {1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_small: got valid=%b ready=%b cnt=%0d, required 0 1 0",
                     bus2.pix_valid, bus2.img_ready, frame_cnt2);
        end
    endtask

    task automatic test_x_image();
        do_reset();
        bus.pix_ready = 1'b1;
        expect_lit(32'h01ffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffff01);
        push_raw({24'h01ff01, 24'hff01ff, 24'h01ff01});
        total++;
        if ({bus.pix_valid, bus.win_first, bus.win_last, frame_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL x_first: got valid=%b first=%b last=%b cnt=%0d, required 1 1 0 0",
                     bus.pix_valid, bus.win_first, bus.win_last, frame_cnt);
        end
        repeat (3) step();
        total++;
        if ({bus.win_first, bus.win_last} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL x_last: got first=%b last=%b, required 0 1", bus.win_first, bus.win_last);
        end
        step();
        total++;
        if ({bus.pix_valid, frame_cnt, sb.size() == 0} !== {1'b0, 8'd1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL x_done: got valid=%b cnt=%0d pending=%0d, required 0 1 0",
                     bus.pix_valid, frame_cnt, sb.size());
        end
    endtask

    task automatic test_stall();
        int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [31:0] prev_pix;
        logic [1:0]  prev_idx;
        do_reset();
        expect_lit(32'hffffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffffff);
        push_raw({24'hffff01, 24'hff01ff, 24'h01ffff});
        prev_pix = '0;
        prev_idx = '0;
        for (int k = 0; k < 7; k++) begin
            bus.pix_ready = pat[k][0];
            if (k > 0 && pat[k-1] == 0) begin
                total++;
                if ({bus.pix_valid, bus.pixels, bus.win_idx} !== {1'b1, prev_pix, prev_idx}) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got valid=%b pixels=%h idx=%0d, required 1 %h %0d",
                             bus.pix_valid, bus.pixels, bus.win_idx, prev_pix, prev_idx);
                end
            end
            prev_pix = bus.pixels;
            prev_idx = bus.win_idx;
            step();
        end
        bus.pix_ready = 1'b0;
        total++;
        if ({bus.pix_valid, frame_cnt, sb.size() == 0} !== {1'b0, 8'd1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL stall_done: got valid=%b cnt=%0d pending=%0d, required 0 1 0",
                     bus.pix_valid, frame_cnt, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] img_a, img_b, img_c;
        int          x0;
        do_reset();
        img_a = rand_img();
        img_b = rand_img();
        img_c = rand_img();
        expect_img(img_a);
        push_raw(img_a);
        expect_img(img_b);
        push_raw(img_b);
        bus.img_valid = 1'b1;
        bus.img_data  = img_c;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({bus.img_ready, bus.pix_valid, bus.win_idx} !== {1'b0, 1'b1, 2'd0}) begin
                bad++;
                $display("[TB] FAIL full_hold: got ready=%b valid=%b idx=%0d, required 0 1 0",
                         bus.img_ready, bus.pix_valid, bus.win_idx);
            end
            step();
        end
        bus.pix_ready = 1'b1;
        x0 = n_xfer;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.img_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_ready_%0d: got img_ready=%b, required 0", i, bus.img_ready);
            end
            step();
        end
        total++;
        if (bus.img_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_pop: got img_ready=%b, required 1", bus.img_ready);
        end
        expect_img(img_c);
        step();
        bus.img_valid = 1'b0;
        repeat (7) step();
        total++;
        if ({n_xfer - x0, bus.pix_valid, frame_cnt, sb.size() == 0} !== {32'd12, 1'b0, 8'd3, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_stream: got xfers=%0d valid=%b cnt=%0d pending=%0d, required 12 0 3 0",
                     n_xfer - x0, bus.pix_valid, frame_cnt, sb.size());
        end
        bus.pix_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [71:0] img;
        do_reset();
        bus.pix_ready = 1'b1;
        img = rand_img();
        expect_img(img);
        push_raw(img);
        repeat (4) step();
        bus.pix_ready = 1'b0;
        img = rand_img();
        expect_img(img);
        push_raw(img);
        img = rand_img();
        expect_img(img);
        push_raw(img);
        bus.pix_ready = 1'b1;
        step();
        step();
        total++;
        if ({bus.win_idx, frame_cnt} !== {2'd2, 8'd1}) begin
            bad++;
            $display("[TB] FAIL pre_flush: got idx=%0d cnt=%0d, required 2 1", bus.win_idx, frame_cnt);
        end
        flush         = 1'b1;
        bus.img_valid = 1'b1;
        bus.img_data  = rand_img();
        step();
        flush         = 1'b0;
        bus.img_valid = 1'b0;
        bus.pix_ready = 1'b0;
        sb.delete();
        total++;
        if ({bus.pix_valid, bus.win_idx, bus.img_ready, frame_cnt} !== {1'b0, 2'd0, 1'b1, 8'd1}) begin
            bad++;
            $display("[TB] FAIL post_flush: got valid=%b idx=%0d ready=%b cnt=%0d, required 0 0 1 1",
                     bus.pix_valid, bus.win_idx, bus.img_ready, frame_cnt);
        end
        step();
        total++;
        if (bus.pix_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_drop_push: got pix_valid=%b, required 0", bus.pix_valid);
        end
        bus.pix_ready = 1'b1;
        img = rand_img();
        expect_img(img);
        push_raw(img);
        total++;
        if ({bus.pix_valid, bus.win_first, bus.win_idx} !== {1'b1, 1'b1, 2'd0}) begin
            bad++;
            $display("[TB] FAIL flush_restart: got valid=%b first=%b idx=%0d, required 1 1 0",
                     bus.pix_valid, bus.win_first, bus.win_idx);
        end
        repeat (4) step();
        total++;
        if ({frame_cnt, sb.size() == 0} !== {8'd2, 1'b1}) begin
            bad++;
            $display("[TB] FAIL flush_after: got cnt=%0d pending=%0d, required 2 0", frame_cnt, sb.size());
        end
        bus.pix_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [71:0] img;
        do_reset();
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            img = rand_img();
            expect_img(img);
            push_raw(img);
        end
        wait_drain(100);
        total++;
        if (frame_cnt !== 8'd5) begin
            bad++;
            $display("[TB] FAIL five_frames: got cnt=%0d, required 5", frame_cnt);
        end
        img = rand_img();
        expect_img(img);
        push_raw(img);
        step();
        total++;
        if (bus.win_idx !== 2'd1) begin
            bad++;
            $display("[TB] FAIL pre_rst_idx: got %0d, required 1", bus.win_idx);
        end
        rst           = 1'b1;
        bus.pix_ready = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        check_reset_outputs("mid_rst");
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        bus2.pix_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.img_valid = 1'b1;
            bus2.img_data  = rand_img();
            step();
            bus2.img_valid = 1'b0;
            repeat (4) step();
            total++;
            if (frame_cnt2 !== seq[i]) begin
                bad++;
                $display("[TB] FAIL cnt_wrap_%0d: got %0d, required %0d", i, frame_cnt2, seq[i]);
            end
        end
        bus2.pix_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        bus.img_valid  = 1'b0;
        bus.img_data   = '0;
        bus.pix_ready  = 1'b0;
        bus2.img_valid = 1'b0;
        bus2.img_data  = '0;
        bus2.pix_ready = 1'b0;
        test_reset();
        test_x_image();
        test_stall();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
